conv2d_stream: RTL
==================

CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8: unsigned pixel width, input and output.
REQ-002 SHALL have parameter COEF_W, default 8: signed kernel coefficient width.
REQ-003 SHALL have parameter IMG_W, default 64: pixels per line, range 3..4096.
REQ-004 SHALL have parameter IMG_H, default 64: lines per frame, range 3..4096.
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the sum before clamping.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port KERNEL, input, 9*COEF_W: signed 3x3 kernel, row-major; k0 in bits [COEF_W-1:0] = top-left, k8 = bottom-right.
REQ-009 SHALL have port abs_en, input, 1: 1 = take absolute value of the shifted sum before clamping.
REQ-010 SHALL have ports in_pix (input, PIX_W), in_valid (input, 1) and in_ready (output, 1): raster-order pixel stream.
REQ-011 SHALL have ports out_pix (output, PIX_W), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): result stream; out_last marks the final pixel of a frame.

Function
REQ-012 SHALL accept a pixel only on a cycle with in_valid && in_ready.
REQ-013 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters that advance per accepted pixel; col wraps to 0 and increments row; row wraps to 0 after pixel (IMG_H-1, IMG_W-1); the next accepted pixel is (0,0) of a new frame.
REQ-014 SHALL keep two IMG_W-deep line buffers plus a 3x3 window register, all shifted on each accepted pixel.
REQ-015 SHALL compute exactly one output per accepted pixel (r,c) with r>=2 and c>=2, using window rows r-2..r and cols c-2..c; no border padding; (IMG_W-2)*(IMG_H-2) outputs per frame in raster order.
REQ-016 SHALL form sum = sum of k_i*p_i with p_i zero-extended, held in a signed accumulator of PIX_W+COEF_W+5 bits; sum SHALL never overflow.
REQ-017 SHALL apply an arithmetic shift right by SHIFT, then abs if abs_en, then clamp: <0 -> 0; >2^PIX_W-1 -> 2^PIX_W-1.
REQ-018 SHALL sample KERNEL and abs_en only when pixel (0,0) is accepted; changes at any other time SHALL take effect from the next frame.
REQ-019 SHALL use a 2-stage pipeline (products, then sum/shift/clamp) followed by the output register; out_valid SHALL rise 2 cycles after the accepting edge when there is no stall.
REQ-020 SHALL use a global pipeline enable en = !out_valid || out_ready; in_ready = en; no stage advances when en = 0.
REQ-021 SHALL hold out_pix and out_last stable while out_valid && !out_ready; it SHALL never drop or duplicate an output.
REQ-022 SHALL assert out_last with the output from input pixel (IMG_H-1, IMG_W-1).
REQ-023 SHALL process a frame whose last pixel and the next frame's (0,0) are accepted back-to-back without bubbles.

Reset
REQ-024 SHALL, while rst is high, clear col, row, window, pipeline valid bits, out_valid, out_pix and out_last to 0 and the sampled kernel to 0; in_ready SHALL be 0 during reset.
REQ-025 SHALL leave line-buffer contents uncleared; stale data SHALL never reach an output.
REQ-026 SHALL, after a mid-frame reset, treat the next accepted pixel as (0,0); no output from the aborted frame SHALL appear.

Structure
REQ-027 SHALL place the kernel tap count (9), the accumulator width function and the clamp/saturation function in a shared package conv_pkg.
REQ-028 SHALL implement each line buffer as one instance of sub-module line_buf (depth IMG_W, width PIX_W, single read/write pointer, advances only on accept).

Verification
REQ-029 SHALL be checked with IMG_W=IMG_H=8, all pixels 0x7D, KERNEL all 0xFF, abs_en=0 -> 36 outputs of 0x00; with abs_en=1 -> 36 outputs of 0xFF (|-1125| clamped).
REQ-030 SHALL be checked with identity kernel (k4=1, rest 0) and ramp pixel = r*8+c -> output n (raster over r,c in 1..6) = r*8+c.
REQ-031 SHALL be checked with KERNEL all 0x01, SHIFT=3, pixels 0x10 -> all outputs 0x12 (144>>3).
REQ-032 SHALL be checked with out_ready toggling 1,0,0,1 and in_valid random -> 36 correct outputs in order, out_last only on the 36th, in_ready low on every stalled cycle.
REQ-033 SHALL be checked with rst pulsed for one cycle after 20 accepted pixels, then a full frame -> no output until pixel (2,2) of the new frame, then 36 correct outputs.
REQ-034 SHALL be checked with KERNEL changed from identity to all-0x01 at pixel (3,3) -> rest of frame still identity; next frame uses all-0x01.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : tap count and arithmetic helpers shared by the conv2d_stream files
// Revision : 1.0
// ============================================================================
package conv_pkg;

  localparam int TAPS = 9;

  function automatic int acc_width(input int pix_w, input int coef_w);
    return pix_w + coef_w + 5;
  endfunction

  // Saturate a signed value into the unsigned pixel range 0 .. 2^pix_w-1.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int pix_w);
    logic signed [63:0] maxv;
    maxv = (64'sd1 <<< pix_w) - 64'sd1;
    if (v < 64'sd0) return '0;
    if (v > maxv) return maxv;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// ============================================================================
// line_buf : one image line of delay, single shared read/write pointer
// Revision : 1.0
// ============================================================================
module line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int C_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_PW-1:0]  r_ptr;

  // Read-before-write: dout is the sample written exactly DEPTH advances ago.
  assign dout = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (adv) begin
      r_ptr <= (r_ptr == C_PW'(DEPTH - 1)) ? '0 : r_ptr + C_PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      r_mem[r_ptr] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
// conv2d_stream : streaming 3x3 valid-region convolution with shift/abs/clamp
// Revision : 1.0
// ============================================================================
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int SHIFT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAPS*COEF_W-1:0] KERNEL,
  input  logic                   abs_en,
  input  logic [PIX_W-1:0]       in_pix,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [PIX_W-1:0]       out_pix,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int C_ACC_W  = acc_width(PIX_W, COEF_W);
  localparam int C_PROD_W = PIX_W + COEF_W + 1;
  localparam int C_CW     = $clog2(IMG_W);
  localparam int C_RW     = $clog2(IMG_H);

  logic                       w_en, w_accept, w_first, w_frame_end, w_emit;
  logic [C_CW-1:0]            r_col;
  logic [C_RW-1:0]            r_row;
  logic [PIX_W-1:0]           r_win [3][3];
  logic [PIX_W-1:0]           w_win [3][3];
  logic [PIX_W-1:0]           w_lb0, w_lb1;
  logic [TAPS*COEF_W-1:0]     r_kern;
  logic                       r_abs;
  logic signed [C_PROD_W-1:0] w_coef [TAPS];
  logic signed [C_PROD_W-1:0] w_pixe [TAPS];
  logic signed [C_PROD_W-1:0] w_prod [TAPS];
  logic signed [C_PROD_W-1:0] r_prod [TAPS];
  logic                       r_s1_valid, r_s1_last, r_s1_abs;
  logic signed [C_ACC_W-1:0]  w_sum, w_shift;
  logic signed [63:0]         w_wide;
  logic [PIX_W-1:0]           r_s2_pix;
  logic                       r_s2_valid, r_s2_last;

  assign w_en        = !out_valid || out_ready;
  assign in_ready    = w_en && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_first     = (r_col == '0) && (r_row == '0);
  assign w_frame_end = (r_col == C_CW'(IMG_W - 1)) && (r_row == C_RW'(IMG_H - 1));
  assign w_emit      = (r_col >= C_CW'(2)) && (r_row >= C_RW'(2));

  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .adv(w_accept), .din(in_pix), .dout(w_lb0)
  );
  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .adv(w_accept), .din(w_lb0), .dout(w_lb1)
  );

  // Window as it looks once the incoming column (r-2, r-1, r) is shifted in.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win[i][0] = r_win[i][1];
      w_win[i][1] = r_win[i][2];
    end
    w_win[0][2] = w_lb1;
    w_win[1][2] = w_lb0;
    w_win[2][2] = in_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_kern <= '0;
      r_abs  <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else if (w_accept) begin
      r_win <= w_win;
      if (w_first) begin
        r_kern <= KERNEL;
        r_abs  <= abs_en;
      end
      if (r_col == C_CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == C_RW'(IMG_H - 1)) ? '0 : r_row + C_RW'(1);
      end else begin
        r_col <= r_col + C_CW'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_coef[k] = {{(C_PROD_W - COEF_W){r_kern[k*COEF_W + COEF_W - 1]}},
                   r_kern[k*COEF_W +: COEF_W]};
      w_pixe[k] = {{(C_PROD_W - PIX_W){1'b0}}, w_win[k/3][k%3]};
      w_prod[k] = w_coef[k] * w_pixe[k];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++)
      w_sum = w_sum + {{(C_ACC_W - C_PROD_W){r_prod[k][C_PROD_W-1]}}, r_prod[k]};
  end

  assign w_shift = w_sum >>> SHIFT;

  always_comb begin
    w_wide = {{(64 - C_ACC_W){w_shift[C_ACC_W-1]}}, w_shift};
    if (r_s1_abs && (w_wide < 64'sd0)) w_wide = -w_wide;
  end

  // Every stage, including the output register, moves only on w_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_abs   <= 1'b0;
      r_s2_pix   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      out_pix    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (w_en) begin
      r_prod     <= w_prod;
      r_s1_valid <= w_accept && w_emit;
      r_s1_last  <= w_accept && w_frame_end;
      r_s1_abs   <= r_abs;
      r_s2_pix   <= PIX_W'(sat_clamp(w_wide, PIX_W));
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      out_pix    <= r_s2_pix;
      out_valid  <= r_s2_valid;
      out_last   <= r_s2_last;
    end
  end

endmodule
`default_nettype wire
